stereo_frame_seq: RTL and testbench

Frame/line sequencer for the stereo census datapath. Watches both camera sync streams, enforces left/right lockstep, generates pixel coordinates and the core enable, and qualifies the core's disparity output against the census-window border. Sits between doublecam and stereo2. Sticky error bits report sync and geometry faults.

---
 rtl/stereo_frame_seq.sv | 202 ++++++++++++++++++++
 tb/tb_stereo_frame_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_frame_seq.sv
// Stereo frame/line sequencer: keeps left/right sync streams in lockstep, numbers pixels,
// enables the census core and qualifies its delayed output against the window border.
module stereo_frame_seq #(
  parameter int H_ACTIVE = 16,
  parameter int V_ACTIVE = 12,
  parameter int BORDER   = 2,
  parameter int LAT      = 4
) (
  input  logic       pxclk,
  input  logic       reset,
  input  logic       lLine,
  input  logic       lFrame,
  input  logic       rLine,
  input  logic       rFrame,
  input  logic       coreValid,
  input  logic       errClr,
  output logic       coreEn,
  output logic       coreFlush,
  output logic [9:0] pixX,
  output logic [9:0] pixY,
  output logic       outValid,
  output logic [9:0] outX,
  output logic [9:0] outY,
  output logic       frameDone,
  output logic [7:0] frameCnt,
  output logic [2:0] errCode
);

  localparam logic [9:0]  LP_X_MIN = 10'(BORDER);
  localparam logic [9:0]  LP_X_END = 10'(H_ACTIVE - BORDER);
  localparam logic [9:0]  LP_Y_MIN = 10'(BORDER);
  localparam logic [9:0]  LP_Y_END = 10'(V_ACTIVE - BORDER);
  localparam logic [9:0]  LP_H     = 10'(H_ACTIVE);
  localparam logic [10:0] LP_V     = 11'(V_ACTIVE);
  localparam logic [9:0]  LP_SAT   = 10'd1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_armed;
  logic        w_armed_nxt;
  logic        r_lline_q;
  logic        r_frm_err;
  logic [9:0]  r_pix_x;
  logic [9:0]  r_pix_y;
  logic        r_frame_done;
  logic [7:0]  r_frame_cnt;
  logic [2:0]  r_err;
  logic [2:0]  w_err_set;
  logic        w_both_hi;
  logic        w_both_lo;
  logic        w_mismatch;
  logic        w_in_frame;
  logic        w_core_en;
  logic        w_line_end;
  logic        w_frame_end;
  logic        w_len_err;
  logic        w_cnt_err;
  logic        w_clean;
  logic        w_start;
  logic        w_win;
  logic [10:0] w_lines;
  logic        r_pipe_w [LAT];
  logic [9:0]  r_pipe_x [LAT];
  logic [9:0]  r_pipe_y [LAT];

  assign w_both_hi   = lFrame & rFrame;
  assign w_both_lo   = ~lFrame & ~rFrame;
  assign w_mismatch  = (lLine ^ rLine) | (lFrame ^ rFrame);
  assign w_in_frame  = (r_state == ST_FRAME);
  assign w_core_en   = w_in_frame & lLine & rLine & w_both_hi;
  assign w_line_end  = w_in_frame & ~w_mismatch & r_lline_q & ~lLine;
  assign w_frame_end = w_in_frame & ~w_mismatch & w_both_lo;
  assign w_len_err   = w_line_end & (r_pix_x != LP_H);
  // A line may end in the same cycle as the frame, so it still counts here.
  assign w_lines     = {1'b0, r_pix_y} + {10'd0, w_line_end};
  assign w_cnt_err   = w_frame_end & (w_lines != LP_V);
  assign w_clean     = w_frame_end & ~w_cnt_err & ~w_len_err & ~r_frm_err;
  assign w_start     = (r_state == ST_IDLE) & (w_state_nxt == ST_FRAME);
  assign w_win       = w_core_en & (r_pix_x >= LP_X_MIN) & (r_pix_x < LP_X_END)
                       & (r_pix_y >= LP_Y_MIN) & (r_pix_y < LP_Y_END);

  // Next state, arming and error-set decode
  always_comb begin
    w_state_nxt = r_state;
    w_armed_nxt = r_armed;
    w_err_set   = 3'b000;
    case (r_state)
      ST_IDLE: begin
        if (w_both_lo) w_armed_nxt = 1'b1;
        else           w_armed_nxt = r_armed;
        if (r_armed && w_both_hi) begin
          w_state_nxt = ST_FRAME;
        end else if (r_armed && (lFrame ^ rFrame)) begin
          w_state_nxt  = ST_ERROR;
          w_err_set[0] = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FRAME: begin
        if (w_mismatch) begin
          w_state_nxt  = ST_ERROR;
          w_err_set[0] = 1'b1;
        end else if (w_frame_end) begin
          w_state_nxt = ST_IDLE;
          w_armed_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_FRAME;
        end
      end
      ST_ERROR: begin
        if (w_both_lo) begin
          w_state_nxt = ST_IDLE;
          w_armed_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_ERROR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_armed_nxt = 1'b0;
      end
    endcase
    w_err_set[1] = w_len_err;
    w_err_set[2] = w_cnt_err;
  end

  // Control state, coordinates, frame counting and sticky errors
  always_ff @(posedge pxclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_lline_q    <= 1'b0;
      r_frm_err    <= 1'b0;
      r_pix_x      <= 10'd0;
      r_pix_y      <= 10'd0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_err        <= 3'b000;
    end else begin
      r_state      <= w_state_nxt;
      r_armed      <= w_armed_nxt;
      r_lline_q    <= lLine;
      r_frame_done <= w_clean;
      r_err        <= (errClr ? 3'b000 : r_err) | w_err_set;
      if (w_clean) r_frame_cnt <= r_frame_cnt + 8'd1;
      else         r_frame_cnt <= r_frame_cnt;
      if (w_start)        r_frm_err <= 1'b0;
      else if (w_len_err) r_frm_err <= 1'b1;
      else                r_frm_err <= r_frm_err;
      if (w_start) begin
        r_pix_x <= 10'd0;
        r_pix_y <= 10'd0;
      end else if (w_line_end) begin
        r_pix_x <= 10'd0;
        r_pix_y <= (r_pix_y == LP_SAT) ? r_pix_y : r_pix_y + 10'd1;
      end else if (w_core_en) begin
        r_pix_x <= (r_pix_x == LP_SAT) ? r_pix_x : r_pix_x + 10'd1;
      end else begin
        r_pix_x <= r_pix_x;
      end
    end
  end

  // Core-latency alignment of window flag and coordinates
  always_ff @(posedge pxclk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_pipe_w[i] <= 1'b0;
        r_pipe_x[i] <= 10'd0;
        r_pipe_y[i] <= 10'd0;
      end
    end else begin
      r_pipe_w[0] <= w_win;
      r_pipe_x[0] <= w_core_en ? r_pix_x : 10'd0;
      r_pipe_y[0] <= w_core_en ? r_pix_y : 10'd0;
      for (int i = 1; i < LAT; i++) begin
        r_pipe_w[i] <= r_pipe_w[i-1];
        r_pipe_x[i] <= r_pipe_x[i-1];
        r_pipe_y[i] <= r_pipe_y[i-1];
      end
    end
  end

  assign coreEn    = w_core_en;
  assign coreFlush = (r_state == ST_ERROR);
  assign pixX      = r_pix_x;
  assign pixY      = r_pix_y;
  assign outValid  = r_pipe_w[LAT-1] & coreValid;
  assign outX      = r_pipe_x[LAT-1];
  assign outY      = r_pipe_y[LAT-1];
  assign frameDone = r_frame_done;
  assign frameCnt  = r_frame_cnt;
  assign errCode   = r_err;

endmodule

// File: tb/tb_stereo_frame_seq.sv
// Self-checking bench for stereo_frame_seq: frame-level reference model, a vector table for
// arming/error corners, and randomized lockstep frames.
module tb_stereo_frame_seq;

  localparam int H = 8;
  localparam int V = 6;
  localparam int B = 1;
  localparam int L = 3;

  logic       pxclk = 1'b0;
  logic       reset, lLine, lFrame, rLine, rFrame, coreValid, errClr;
  logic       coreEn, coreFlush, outValid, frameDone;
  logic [9:0] pixX, pixY, outX, outY;
  logic [7:0] frameCnt;
  logic [2:0] errCode;

  stereo_frame_seq #(.H_ACTIVE(H), .V_ACTIVE(V), .BORDER(B), .LAT(L)) dut (
    .pxclk(pxclk), .reset(reset), .lLine(lLine), .lFrame(lFrame), .rLine(rLine),
    .rFrame(rFrame), .coreValid(coreValid), .errClr(errClr), .coreEn(coreEn),
    .coreFlush(coreFlush), .pixX(pixX), .pixY(pixY), .outValid(outValid), .outX(outX),
    .outY(outY), .frameDone(frameDone), .frameCnt(frameCnt), .errCode(errCode)
  );

  always #5 pxclk = ~pxclk;

  typedef struct packed {logic w; int x; int y;} pipe_t;
  typedef struct {logic ll, lf, rl, rf, en, fl; int x, y; logic [2:0] err;} vec_t;

  int         n_pass = 0;
  int         n_total = 0;
  int         n_en = 0;
  int         n_ov = 0;
  int         n_fd = 0;
  int         m_cnt = 0;
  logic [2:0] m_err = 3'b000;
  logic       m_fd = 1'b0;
  int         lens [16];
  pipe_t      dq [$];
  vec_t       tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic clear_pipe();
    dq.delete();
    for (int i = 0; i < L; i++) dq.push_back('{w: 1'b0, x: 0, y: 0});
  endtask

  function automatic logic cvb(input int m);
    if (m == 0)      return 1'b1;
    else if (m == 1) return 1'b0;
    else             return 1'($urandom_range(0, 1));
  endfunction

  function automatic vec_t mk(input logic ll, lf, rl, rf, en, fl, input int x, y,
                              input logic [2:0] err);
    vec_t v;
    v = '{ll: ll, lf: lf, rl: rl, rf: rf, en: en, fl: fl, x: x, y: y, err: err};
    return v;
  endfunction

  // One pixel clock: drive, compare against the model, advance.
  task automatic step(input logic ll, lf, rl, rf, cv, clr, e_en, input int e_x, e_y,
                      input logic e_fl);
    pipe_t d;
    lLine = ll; lFrame = lf; rLine = rl; rFrame = rf; coreValid = cv; errClr = clr;
    #2;
    d = dq.pop_front();
    dq.push_back('{w: e_en && e_x >= B && e_x < H - B && e_y >= B && e_y < V - B,
                   x: e_x, y: e_y});
    check("coreEn", coreEn, e_en);
    if (e_en) begin
      check("pixX", pixX, e_x);
      check("pixY", pixY, e_y);
    end
    check("coreFlush", coreFlush, e_fl);
    check("outValid", outValid, d.w & cv);
    if (d.w && cv) begin
      check("outX", outX, d.x);
      check("outY", outY, d.y);
    end
    check("frameDone", frameDone, m_fd);
    check("frameCnt", frameCnt, m_cnt[7:0]);
    check("errCode", errCode, m_err);
    if (coreEn) n_en++;
    if (outValid) n_ov++;
    if (frameDone) n_fd++;
    @(posedge pxclk);
    @(negedge pxclk);
    if (reset) begin
      clear_pipe();
      m_cnt = 0; m_err = 3'b000; m_fd = 1'b0;
    end else if (clr) begin
      m_err = 3'b000;
    end
  endtask

  task automatic set_lens(input int v);
    for (int i = 0; i < 16; i++) lens[i] = v;
  endtask

  // Lockstep frame of nl lines with lens[] pixels; fault_line>=0 drops rLine early there.
  task automatic run_frame(input int nl, input int cvm, input int fault_line);
    logic bad;
    int   g;
    bad = 1'b0;
    g = 1 + $urandom_range(0, 2);
    for (int i = 0; i < g; i++) step(0, 0, 0, 0, cvb(cvm), 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1, cvb(cvm), 0, 0, 0, 0, 0);
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < lens[y]; x++) begin
        if (y == fault_line && x == lens[y] - 1) begin
          step(1, 1, 0, 1, cvb(cvm), 0, 0, 0, 0, 0);
          m_err[0] = 1'b1;
          for (int i = 0; i < 3; i++) step(0, 1, 0, 1, cvb(cvm), 0, 0, 0, 0, 1);
          step(0, 0, 0, 0, cvb(cvm), 0, 0, 0, 0, 1);
          step(0, 0, 0, 0, cvb(cvm), 0, 0, 0, 0, 0);
          return;
        end
        step(1, 1, 1, 1, cvb(cvm), 0, 1, x, y, 0);
      end
      step(0, 1, 0, 1, cvb(cvm), 0, 0, 0, 0, 0);
      if (lens[y] != H) begin
        m_err[1] = 1'b1;
        bad = 1'b1;
      end
      g = 1 + $urandom_range(0, 1);
      for (int i = 0; i < g; i++) step(0, 1, 0, 1, cvb(cvm), 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, cvb(cvm), 0, 0, 0, 0, 0);
    if (!bad && nl == V) begin
      m_fd = 1'b1;
      m_cnt++;
    end else if (nl != V) begin
      m_err[2] = 1'b1;
    end
    step(0, 0, 0, 0, cvb(cvm), 0, 0, 0, 0, 0);
    m_fd = 1'b0;
  endtask

  initial begin
    int e0, o0, f0, nl;
    tbl[0]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 3'b000);
    tbl[1]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 3'b000);
    tbl[2]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 3'b000);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
    tbl[5]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 3'b001);
    tbl[6]  = mk(1, 1, 1, 1, 0, 1, 0, 0, 3'b001);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b001);
    tbl[8]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 3'b001);
    tbl[9]  = mk(1, 1, 1, 1, 1, 0, 0, 0, 3'b001);
    tbl[10] = mk(1, 1, 1, 1, 1, 0, 1, 0, 3'b001);
    tbl[11] = mk(0, 1, 0, 1, 0, 0, 0, 0, 3'b001);
    tbl[12] = mk(0, 1, 0, 1, 0, 0, 0, 0, 3'b011);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b011);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b111);

    reset = 1'b1; lLine = 1'b0; lFrame = 1'b0; rLine = 1'b0; rFrame = 1'b0;
    coreValid = 1'b0; errClr = 1'b0;
    clear_pipe();
    @(negedge pxclk);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Clean frame with coreValid high
    set_lens(H);
    e0 = n_en; o0 = n_ov; f0 = n_fd;
    run_frame(V, 0, -1);
    check("t1_coreEn_cycles", n_en - e0, 48);
    check("t1_outValid_cycles", n_ov - o0, 24);
    check("t1_frameDone_pulses", n_fd - f0, 1);

    // Clean frame with coreValid low
    o0 = n_ov; f0 = n_fd;
    run_frame(V, 1, -1);
    check("t2_outValid_cycles", n_ov - o0, 0);
    check("t2_frameDone_pulses", n_fd - f0, 1);

    // rLine drops early on line 2, then a clean frame
    run_frame(V, 0, 2);
    run_frame(V, 0, -1);
    check("t3_frameCnt", frameCnt, 3);

    // Short line 3, then errClr
    f0 = n_fd;
    lens[3] = H - 1;
    run_frame(V, 0, -1);
    set_lens(H);
    check("t4_frameDone_pulses", n_fd - f0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Five-line frame
    f0 = n_fd;
    run_frame(V - 1, 0, -1);
    check("t5_frameDone_pulses", n_fd - f0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

    // Randomized lockstep frames
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 5))
        0:       nl = V - 1;
        1:       nl = V + 1;
        default: nl = V;
      endcase
      for (int i = 0; i < 16; i++)
        lens[i] = ($urandom_range(0, 5) == 0) ? 7 + 2 * $urandom_range(0, 1) : H;
      run_frame(nl, 2, -1);
      if ($urandom_range(0, 2) == 0) step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    end
    set_lens(H);

    // Reset asserted mid-line
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int x = 0; x < 3; x++) step(1, 1, 1, 1, 1, 0, 1, x, 0, 0);
    reset = 1'b1;
    step(1, 1, 1, 1, 1, 0, 1, 3, 0, 0);
    check("rst_pixX", pixX, 0);
    check("rst_pixY", pixY, 0);
    check("rst_outX", outX, 0);
    check("rst_outY", outY, 0);
    step(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Frames high at release, IDLE mismatch, short frame errors
    for (int i = 0; i < 15; i++) begin
      m_err = tbl[i].err;
      step(tbl[i].ll, tbl[i].lf, tbl[i].rl, tbl[i].rf, 1'b1, 1'b0, tbl[i].en,
           tbl[i].x, tbl[i].y, tbl[i].fl);
    end
    m_err = 3'b111;
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    run_frame(V, 0, -1);
    check("final_frameCnt", frameCnt, 1);
    check("final_errCode", errCode, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
